// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_pkg;

  // Sequencer states, in the order a transaction walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Divider select codes understood by the SPI master (sck = clk / N).
  localparam logic [1:0] SPI_DIV_1 = 2'b00;
  localparam logic [1:0] SPI_DIV_2 = 2'b01;
  localparam logic [1:0] SPI_DIV_4 = 2'b10;
  localparam logic [1:0] SPI_DIV_8 = 2'b11;

  localparam int SPI_BYTE_W = 8;

  // Larger of two integers; used to size the shared SETUP/START counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin priority encoder.
// The search starts at ptr+1 and wraps modulo NREQ, so the requester at
// ptr (the one served last) has the lowest priority.
module spi_rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  // Walk distances from farthest to nearest so the nearest set bit is
  // the last one written and therefore wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ((i == int'(ptr) + k) || (i == int'(ptr) + k - NREQ))) begin
          any     = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one SPI master
// between NREQ requesters.
//
// Handshake: a requester raises req_valid[i] with its byte, bit order and
// divider, and holds them until it sees req_ready[i]. req_ready[i] is a
// registered one-cycle pulse that follows the grant; the request fields are
// captured on the grant edge, so anything the requester drives afterwards is
// ignored. The result comes back as a one-cycle rsp_valid[i] pulse with
// rsp_data/rsp_err alongside; there is no back-pressure on the response.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_msb,
  input  logic [NREQ*2-1:0]       req_div,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [SPI_BYTE_W-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic [SPI_BYTE_W-1:0]   spi_data_trans,
  output logic                    spi_msb,
  output logic [1:0]              spi_div,
  input  logic                    spi_flag,
  input  logic [SPI_BYTE_W-1:0]   spi_data_rec,
  output logic [2:0]              dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(max_int(SETUP_CYC, TIMEOUT)) + 1;
  localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]         req_ready_q, req_ready_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [SPI_BYTE_W-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    spi_start_q, spi_start_d;
  logic [SPI_BYTE_W-1:0]   spi_data_q, spi_data_d;
  logic                    spi_msb_q, spi_msb_d;
  logic [1:0]              spi_div_q, spi_div_d;

  logic [PW-1:0]           gnt_idx;
  logic                    gnt_any;
  logic [NREQ-1:0]         gnt_onehot;
  logic [NREQ-1:0]         ptr_onehot;
  logic [SPI_BYTE_W-1:0]   sel_data;
  logic                    sel_msb;
  logic [1:0]              sel_div;

  spi_rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Select the granted requester's fields and build its one-hot grant.
  always_comb begin
    sel_data   = '0;
    sel_msb    = 1'b0;
    sel_div    = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_data      = req_data[8*i +: 8];
        sel_msb       = req_msb[i];
        sel_div       = req_div[2*i +: 2];
        gnt_onehot[i] = 1'b1;
      end
    end
  end

  // The owner of the in-flight transaction is the last granted index.
  assign ptr_onehot = NREQ'(1) << ptr_q;

  // Next-state and output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    spi_start_d = spi_start_q;
    spi_data_d  = spi_data_q;
    spi_msb_d   = spi_msb_q;
    spi_div_d   = spi_div_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready_d = gnt_onehot;
          spi_data_d  = sel_data;
          spi_msb_d   = sel_msb;
          spi_div_d   = sel_div;
          ptr_d       = gnt_idx;
          cnt_d       = SETUP_LOAD;
          state_d     = SETUP;
        end
      end

      // Give the master time to see stable data/msb/div before start.
      SETUP: begin
        if (cnt_q == '0) begin
          spi_start_d = 1'b1;
          cnt_d       = TIMEOUT_LOAD;
          state_d     = START;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Drop start as soon as the master reports busy so it cannot
      // re-trigger once it finishes the byte.
      START: begin
        if (spi_flag) begin
          spi_start_d = 1'b0;
          state_d     = BUSY;
        end else if (cnt_q == '0) begin
          spi_start_d = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_valid_d = ptr_onehot;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // sck is derived from clk, so flag and rx data are sampled directly.
      BUSY: begin
        if (!spi_flag) begin
          rsp_err_d   = 1'b0;
          rsp_data_d  = spi_data_rec;
          rsp_valid_d = ptr_onehot;
          state_d     = DONE;
        end
      end

      // rsp_valid is high for this single cycle.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; the pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= PW'(NREQ - 1);
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      spi_start_q <= 1'b0;
      spi_data_q  <= '0;
      spi_msb_q   <= 1'b0;
      spi_div_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      spi_msb_q   <= spi_msb_d;
      spi_div_q   <= spi_div_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign spi_start      = spi_start_q;
  assign spi_data_trans = spi_data_q;
  assign spi_msb        = spi_msb_q;
  assign spi_div        = spi_div_q;
  assign dbg_state      = state_q;

  // Accept and completion pulses are one-hot and never overlap.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready_q));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rstn) $onehot0(rsp_valid_q));
  a_no_overlap:   assert property (@(posedge clk) disable iff (!rstn) !((|req_ready_q) && (|rsp_valid_q)));

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural SPI master/slave, request driver,
// grant and response scoreboards, vector table plus corner-case sequences.
module tb_spi_txn_arbiter;
  import spi_pkg::*;

  localparam int NREQ      = 4;
  localparam int SETUP_CYC = 16;
  localparam int TIMEOUT   = 64;
  localparam int GW        = NREQ + 8 + 1 + 2;   // {ready onehot, data, msb, div}
  localparam int EW        = NREQ + 8 + 1 + 8;   // {rsp onehot, data, err, start cycles}
  localparam int NVEC      = 5;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_msb = '0;
  logic [NREQ*2-1:0] req_div = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              spi_start;
  logic [7:0]        spi_data_trans;
  logic              spi_msb;
  logic [1:0]        spi_div;
  logic              spi_flag;
  logic [7:0]        spi_data_rec;
  logic [2:0]        dbg_state;

  spi_txn_arbiter #(
    .NREQ      (NREQ),
    .SETUP_CYC (SETUP_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_msb        (req_msb),
    .req_div        (req_div),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .spi_start      (spi_start),
    .spi_data_trans (spi_data_trans),
    .spi_msb        (spi_msb),
    .spi_div        (spi_div),
    .spi_flag       (spi_flag),
    .spi_data_rec   (spi_data_rec),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SPI master + slave model ----------------
  // Master: on start it raises flag next edge, shifts 8 bits at one bit per
  // (1<<div) clocks, then spends one cycle in DONE with rx data valid.
  logic [1:0] m_st;
  int         m_cnt;
  int         m_period;
  logic [3:0] m_bit;
  logic [7:0] m_tx, m_rx;
  logic       m_msb;
  logic [2:0] bit_idx;
  logic       mosi, miso;
  logic [7:0] slave_byte = 8'h00;
  logic       loopback = 1'b0;
  logic       tie_flag_low = 1'b0;
  int         flag_rises = 0;

  assign bit_idx      = m_msb ? (3'd7 - m_bit[2:0]) : m_bit[2:0];
  assign mosi         = m_tx[bit_idx];
  assign miso         = loopback ? mosi : slave_byte[bit_idx];
  assign spi_data_rec = (m_st == 2'd2) ? m_rx : 8'hEE;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_st     <= 2'd0;
      spi_flag <= 1'b0;
      m_cnt    <= 0;
      m_period <= 1;
      m_bit    <= 4'd0;
      m_tx     <= 8'h00;
      m_rx     <= 8'h00;
      m_msb    <= 1'b0;
    end else begin
      case (m_st)
        2'd0: begin
          if (spi_start && !tie_flag_low) begin
            m_st       <= 2'd1;
            spi_flag   <= 1'b1;
            m_tx       <= spi_data_trans;
            m_msb      <= spi_msb;
            m_period   <= 1 << spi_div;
            m_cnt      <= 0;
            m_bit      <= 4'd0;
            flag_rises <= flag_rises + 1;
          end
        end
        2'd1: begin
          if (m_cnt == m_period - 1) begin
            m_rx[bit_idx] <= miso;
            m_cnt         <= 0;
            m_bit         <= m_bit + 4'd1;
            if (m_bit == 4'd7) begin
              m_st     <= 2'd2;
              spi_flag <= 1'b0;
            end
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: m_st <= 2'd0;
      endcase
    end
  end

  // ---------------- scoreboard state ----------------
  int              total = 0;
  int              bad = 0;
  logic [GW-1:0]   gnt_q[$];
  logic [EW-1:0]   exp_q[$];
  logic [10:0]     cur_tx = '0;
  logic            in_flight = 1'b0;
  logic            stable_err = 1'b0;
  int              start_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic arm(input int idx, input logic [7:0] d, input logic msb, input logic [1:0] div);
    req_data[8*idx +: 8] = d;
    req_msb[idx]         = msb;
    req_div[2*idx +: 2]  = div;
    req_valid[idx]       = 1'b1;
  endtask

  task automatic expect_txn(input int idx, input logic [7:0] d, input logic msb,
                            input logic [1:0] div, input logic [7:0] rx,
                            input logic err, input int starts);
    gnt_q.push_back({oh(idx), d, msb, div});
    exp_q.push_back({oh(idx), rx, err, 8'(starts)});
  endtask

  // One clock: sample on the falling edge, score grants and responses,
  // and let each requester drop its valid once it sees its ready.
  task automatic tick();
    logic [GW-1:0] g;
    logic [EW-1:0] e;
    @(negedge clk);
    if (req_ready != '0) begin
      check("no_rsp_with_ready", 32'(rsp_valid), 32'd0);
      if (gnt_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant: got req_ready=%b required none", req_ready);
      end else begin
        g = gnt_q.pop_front();
        check("grant", 32'({req_ready, spi_data_trans, spi_msb, spi_div}), 32'(g));
      end
      cur_tx     = {spi_data_trans, spi_msb, spi_div};
      in_flight  = 1'b1;
      stable_err = 1'b0;
      start_cnt  = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) req_valid[i] = 1'b0;
      end
    end
    if (in_flight) begin
      if (spi_start) start_cnt++;
      if ({spi_data_trans, spi_msb, spi_div} !== cur_tx) stable_err = 1'b1;
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL response: got rsp_valid=%b required none", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        check("response", 32'({rsp_valid, rsp_data, rsp_err, 8'(start_cnt)}), 32'(e));
        check("spi_stable", 32'(stable_err), 32'd0);
      end
      in_flight = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || gnt_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, %0d responses outstanding required 0", name, exp_q.size());
      exp_q.delete();
      gnt_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    check({tag, "_spi_data"}, 32'(spi_data_trans), 32'd0);
    check({tag, "_spi_msb"}, 32'(spi_msb), 32'd0);
    check({tag, "_spi_div"}, 32'(spi_div), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       msb;
    logic [1:0] div;
    logic [7:0] slave;
    logic       loop;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[NVEC];

  // ---------------- main sequence ----------------
  initial begin
    int rises0;
    int n;
    vecs[0] = '{0, 8'hA5, 1'b1, SPI_DIV_2, 8'h3C, 1'b0, 8'h3C};
    vecs[1] = '{1, 8'h5A, 1'b0, SPI_DIV_1, 8'hC3, 1'b0, 8'hC3};
    vecs[2] = '{2, 8'hF0, 1'b1, SPI_DIV_4, 8'h0F, 1'b1, 8'hF0};
    vecs[3] = '{3, 8'h01, 1'b0, SPI_DIV_8, 8'h00, 1'b1, 8'h01};
    vecs[4] = '{0, 8'h80, 1'b0, SPI_DIV_8, 8'hAA, 1'b0, 8'hAA};

    // Reset values.
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rstn = 1'b1;
    tick();

    // All four requesters at once, twice: 0,1,2,3 each round.
    for (int r = 0; r < 2; r++) begin
      slave_byte = 8'h5E;
      loopback   = 1'b0;
      arm(0, 8'h11, 1'b1, SPI_DIV_1);
      arm(1, 8'h22, 1'b0, SPI_DIV_2);
      arm(2, 8'h33, 1'b1, SPI_DIV_4);
      arm(3, 8'h44, 1'b0, SPI_DIV_8);
      for (int i = 0; i < NREQ; i++) begin
        expect_txn(i, 8'((i + 1) * 8'h11), (i % 2) == 0, 2'(i), 8'h5E, 1'b0, 2);
      end
      wait_done($sformatf("all_four_round%0d", r), 2000);
    end

    // Single transactions from the table.
    for (int v = 0; v < NVEC; v++) begin
      slave_byte = vecs[v].slave;
      loopback   = vecs[v].loop;
      rises0     = flag_rises;
      arm(vecs[v].idx, vecs[v].data, vecs[v].msb, vecs[v].div);
      expect_txn(vecs[v].idx, vecs[v].data, vecs[v].msb, vecs[v].div, vecs[v].exp_rx, 1'b0, 2);
      wait_done($sformatf("vec%0d", v), 600);
      check($sformatf("vec%0d_flag_rises", v), 32'(flag_rises - rises0), 32'd1);
    end

    // Pointer at 2 with requesters 1 and 3 pending: 3 first, then 1.
    slave_byte = 8'h42;
    loopback   = 1'b0;
    arm(2, 8'h02, 1'b1, SPI_DIV_1);
    expect_txn(2, 8'h02, 1'b1, SPI_DIV_1, 8'h42, 1'b0, 2);
    wait_done("ptr_setup", 600);
    arm(1, 8'hB1, 1'b1, SPI_DIV_2);
    arm(3, 8'hB3, 1'b0, SPI_DIV_1);
    expect_txn(3, 8'hB3, 1'b0, SPI_DIV_1, 8'h42, 1'b0, 2);
    expect_txn(1, 8'hB1, 1'b1, SPI_DIV_2, 8'h42, 1'b0, 2);
    wait_done("ptr_order", 1200);

    // Master never raises flag: start held TIMEOUT cycles, error response.
    tie_flag_low = 1'b1;
    rises0 = flag_rises;
    arm(1, 8'h5C, 1'b0, SPI_DIV_2);
    expect_txn(1, 8'h5C, 1'b0, SPI_DIV_2, 8'h00, 1'b1, TIMEOUT);
    wait_done("timeout", 600);
    check("timeout_no_flag", 32'(flag_rises - rises0), 32'd0);
    tie_flag_low = 1'b0;
    slave_byte = 8'h6D;
    arm(2, 8'h9E, 1'b1, SPI_DIV_4);
    expect_txn(2, 8'h9E, 1'b1, SPI_DIV_4, 8'h6D, 1'b0, 2);
    wait_done("after_timeout", 600);

    // Reset while the master is shifting: outputs clear at once, no response.
    slave_byte = 8'h99;
    arm(2, 8'h77, 1'b1, SPI_DIV_8);
    gnt_q.push_back({oh(2), 8'h77, 1'b1, SPI_DIV_8});
    n = 0;
    while (!spi_flag && n < 100) begin
      tick();
      n++;
    end
    check("busy_before_reset", 32'(spi_flag), 32'd1);
    repeat (3) tick();
    check("busy_state", 32'(dbg_state), 32'(BUSY));
    #2 rstn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    in_flight = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    check("aborted_grant_seen", 32'(gnt_q.size()), 32'd0);
    slave_byte = 8'h24;
    arm(3, 8'hD3, 1'b0, SPI_DIV_1);
    arm(0, 8'hD0, 1'b1, SPI_DIV_2);
    expect_txn(0, 8'hD0, 1'b1, SPI_DIV_2, 8'h24, 1'b0, 2);
    expect_txn(3, 8'hD3, 1'b0, SPI_DIV_1, 8'h24, 1'b0, 2);
    wait_done("after_reset", 1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one SPI master between NREQ requesters.
- Each requester hands over one byte plus its bit-order and clock-divider settings, using a valid/ready handshake.
- The block drives the master's start, data, MSB and divider inputs, and tracks the master's busy flag.
- It returns the received byte to the requester that was granted, and sits between client logic and the SPI master on the system clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETUP_CYC, 16, clk cycles that data/MSB/div are held stable before start is raised. This covers at least one rising sck edge at the slowest divider (clk/8).
- TIMEOUT, 64, maximum clk cycles in START waiting for spi_flag=1 before the transaction is aborted.

Ports:
- clk  in  1  system clock; the same clock that feeds the SPI divider.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
- req_data  in  NREQ*8  tx byte; requester i uses bits [8i+7:8i].
- req_msb  in  NREQ  1 = MSB first.
- req_div  in  NREQ*2  divider select; requester i uses bits [2i+1:2i].
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_data  out  8  received byte; valid while any rsp_valid bit is high.
- rsp_err  out  1  timeout indication; qualified by rsp_valid.
- spi_start  out  1  start request to the SPI master.
- spi_data_trans  out  8  byte to transmit.
- spi_msb  out  1  bit order to the master.
- spi_div  out  2  divider select to the master.
- spi_flag  in  1  master busy (high during shifting).
- spi_data_rec  in  8  master rx byte; valid only while the master is in DONE.

Behaviour:
- Reset values (asynchronous, all zero): req_ready, rsp_valid, rsp_data, rsp_err, spi_start, spi_data_trans, spi_msb and spi_div are 0. The state is IDLE and the round-robin pointer is NREQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-transaction: the state returns to IDLE immediately, no response is issued, and spi_start drops at once.
- States: IDLE, SETUP, START, BUSY, DONE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching upward from pointer+1 with wrap modulo NREQ.
  - In the same cycle: pulse req_ready[g], latch req_data/msb/div of g onto spi_data_trans/spi_msb/spi_div, set pointer = g, load the counter with SETUP_CYC-1, and go to SETUP.
  - A requester whose valid drops before the grant is not served.
- SETUP: hold the SPI outputs stable and decrement the counter. At 0, go to START, assert spi_start, and load the counter with TIMEOUT-1.
- START:
  - Hold spi_start=1.
  - If spi_flag=1: deassert spi_start on the next edge and go to BUSY. This guarantees the master does not re-trigger after its DONE state.
  - Else if the counter reaches 0: deassert spi_start and go to DONE with the error bit set.
  - Otherwise decrement the counter.
- BUSY: wait for spi_flag=0. On the first clk edge where spi_flag is sampled 0, capture spi_data_rec into rsp_data and go to DONE. spi_flag and spi_data_rec are sampled directly with no synchronizer, because sck is derived from clk.
- DONE:
  - Pulse rsp_valid[pointer] for exactly one cycle and drive rsp_err = error bit.
  - On timeout, rsp_data = 8'h00.
  - Then go to IDLE.
  - spi_data_trans/msb/div keep their values until the next grant.
- Throughput: at most one transaction in flight. The minimum request-to-response latency is 1 + SETUP_CYC + (cycles to flag high) + (8 sck periods) + 1 cycle.
- Simultaneous events:
  - A new req_valid during a transaction waits and does not affect the current grant.
  - The just-served requester has the lowest priority in the next arbitration.
  - rsp_valid and req_ready can never be high in the same cycle.
- req_* inputs of non-granted requesters are ignored. Inputs of the granted requester are ignored after the accept cycle.

Decomposition:
- Package spi_pkg holds:
  - enum state_t {IDLE, SETUP, START, BUSY, DONE};
  - localparam SPI_DIV_1 = 2'b00, SPI_DIV_2 = 2'b01, SPI_DIV_4 = 2'b10, SPI_DIV_8 = 2'b11;
  - localparam SPI_BYTE_W = 8.
- One sub-module, spi_rr_picker: a combinational round-robin priority encoder taking (req vector, pointer) and producing (grant index, any).

Test Plan:
- Single request: req0 with data=8'hA5, msb=1, div=2'b01, and a slave model returning 8'h3C → one req_ready[0] pulse, spi_start held until flag rises, rsp_valid[0] pulse with rsp_data=8'h3C and rsp_err=0, outputs stable from SETUP through DONE.
- All four valid after reset with data 8'h11/22/33/44 → served in order 0,1,2,3. Re-asserting all four afterwards is served 0,1,2,3 again because the pointer wraps.
- Pointer at 2 with req1 and req3 pending → req3 is granted first, then req1.
- spi_flag tied 0 → spi_start high for exactly TIMEOUT cycles, then rsp_valid with rsp_err=1 and rsp_data=8'h00, and the next request is served normally.
- rstn pulsed low during BUSY → all outputs 0 the same cycle, no rsp_valid, and the first request after release is granted to requester 0.
- LSB-first transfer at div=2'b11: tx 8'h01 with loopback MOSI→MISO → rsp_data matches the master's rx byte, and there is exactly one transaction (spi_flag rises once).
